// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, instruction register, BYPASS/IDCODE
// data registers and the control strobes for a chain of boundary_cell instances.
module tap_controller #(
    parameter int unsigned          IR_WIDTH   = 4,
    parameter logic [31:0]          IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0]  EXTEST     = IR_WIDTH'(0),
    parameter logic [IR_WIDTH-1:0]  SAMPLE     = IR_WIDTH'(1),
    parameter logic [IR_WIDTH-1:0]  IDCODE     = IR_WIDTH'(2),
    parameter logic [IR_WIDTH-1:0]  BYPASS     = '1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSR_TDO,
    output logic       TDO,
    output logic       TDO_En,
    output logic       Shift_or_Load,
    output logic       Clock_DR,
    output logic       Update_DR,
    output logic       Test_or_Normal,
    output logic [3:0] Tap_State
);

    // Standard 1149.1 state codes, visible on Tap_State for debug.
    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TEST_RESET = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_CHAIN
    } dr_sel_t;

    tap_state_t          state;
    tap_state_t          state_nx;
    logic [IR_WIDTH-1:0] ir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [31:0]         id_sr;
    logic                bypass;
    dr_sel_t             dr_sel;
    logic                chain_sel;
    logic                dr_lsb;

    assign Tap_State = state;

    always_comb begin
        state_nx = state;
        case (state)
            TEST_RESET: state_nx = TMS ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   state_nx = TMS ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  state_nx = TMS ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: state_nx = TMS ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   state_nx = TMS ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   state_nx = TMS ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   state_nx = TMS ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   state_nx = TMS ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  state_nx = TMS ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  state_nx = TMS ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: state_nx = TMS ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   state_nx = TMS ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   state_nx = TMS ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   state_nx = TMS ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   state_nx = TMS ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  state_nx = TMS ? SELECT_DR  : RUN_IDLE;
            default:    state_nx = TEST_RESET;
        endcase
    end

    // Any opcode not claimed by EXTEST/SAMPLE/IDCODE falls through to the bypass flop.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir == EXTEST || ir == SAMPLE) begin
            dr_sel = DR_CHAIN;
        end else if (ir == IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir == BYPASS) begin
            dr_sel = DR_BYPASS;
        end
    end

    assign chain_sel = (dr_sel == DR_CHAIN);

    always_comb begin
        dr_lsb = bypass;
        case (dr_sel)
            DR_CHAIN:  dr_lsb = BSR_TDO;
            DR_IDCODE: dr_lsb = id_sr[0];
            default:   dr_lsb = bypass;
        endcase
    end

    // Strobes are registered from the next state so they are high exactly while the
    // FSM sits in Capture-DR/Shift-DR/Update-DR; ir cannot change on those transitions.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state          <= TEST_RESET;
            ir             <= IDCODE;
            ir_sr          <= '0;
            id_sr          <= '0;
            bypass         <= 1'b0;
            Test_or_Normal <= 1'b0;
            Shift_or_Load  <= 1'b0;
            Clock_DR       <= 1'b0;
            Update_DR      <= 1'b0;
        end else begin
            state <= state_nx;

            case (state)
                CAPTURE_IR: ir_sr <= IR_WIDTH'(1);
                SHIFT_IR:   ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
                CAPTURE_DR: begin
                    id_sr  <= IDCODE_VAL;
                    bypass <= 1'b0;
                end
                SHIFT_DR: begin
                    id_sr  <= {TDI, id_sr[31:1]};
                    bypass <= TDI;
                end
                default: ;
            endcase

            if (state_nx == TEST_RESET) begin
                ir             <= IDCODE;
                Test_or_Normal <= 1'b0;
            end else if (state == UPDATE_IR) begin
                ir             <= ir_sr;
                Test_or_Normal <= (ir_sr == EXTEST);
            end

            Clock_DR      <= chain_sel && (state_nx == CAPTURE_DR || state_nx == SHIFT_DR);
            Shift_or_Load <= chain_sel && (state_nx == SHIFT_DR);
            Update_DR     <= chain_sel && (state_nx == UPDATE_DR);
        end
    end

    always_ff @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            TDO    <= 1'b0;
            TDO_En <= 1'b0;
        end else begin
            case (state)
                SHIFT_IR: begin
                    TDO    <= ir_sr[0];
                    TDO_En <= 1'b1;
                end
                SHIFT_DR: begin
                    TDO    <= dr_lsb;
                    TDO_En <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    TDO_En <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboarded bench for tap_controller: transition-table/queue reference model,
// a 4-cell boundary chain environment, directed scenarios and a random TMS walk.
module tb_tap_controller;

    localparam int          IRW = 4;
    localparam logic [31:0] IDV = 32'h1000_0001;

    localparam int X2D = 'h0, X1D = 'h1, SHD = 'h2, PAD = 'h3, SIR = 'h4, UPD = 'h5;
    localparam int CPD = 'h6, SDR = 'h7, X2I = 'h8, X1I = 'h9, SHI = 'hA, PAI = 'hB;
    localparam int RTI = 'hC, UPI = 'hD, CPI = 'hE, TLR = 'hF;

    // Next state for TMS=0 / TMS=1, indexed by state code.
    localparam int NXT0 [16] = '{SHD, PAD, SHD, PAD, CPI, RTI, SHD, CPD,
                                 SHI, PAI, SHI, PAI, RTI, RTI, SHI, RTI};
    localparam int NXT1 [16] = '{UPD, UPD, X1D, X2D, TLR, SDR, X1D, SIR,
                                 UPI, UPI, X1I, X2I, SDR, SDR, X1I, TLR};

    localparam logic [3:0] OP_EXTEST = 4'b0000;
    localparam logic [3:0] OP_SAMPLE = 4'b0001;
    localparam logic [3:0] OP_IDCODE = 4'b0010;

    logic       Clock, Reset_n, TMS, TDI, BSR_TDO;
    logic       TDO, TDO_En, Shift_or_Load, Clock_DR, Update_DR, Test_or_Normal;
    logic [3:0] Tap_State;

    tap_controller #(.IR_WIDTH(IRW), .IDCODE_VAL(IDV)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .TMS(TMS), .TDI(TDI), .BSR_TDO(BSR_TDO),
        .TDO(TDO), .TDO_En(TDO_En), .Shift_or_Load(Shift_or_Load), .Clock_DR(Clock_DR),
        .Update_DR(Update_DR), .Test_or_Normal(Test_or_Normal), .Tap_State(Tap_State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        int st;
        bit cdr, sol, upd, ton, en;
    } exp_t;

    exp_t ctrl_q[$];
    bit   tdo_q[$];
    int   tests = 0;
    int   fails = 0;

    int         ms;
    logic [3:0] mir;
    bit         mton;
    bit         irq[$];
    bit         drq[$];

    logic [3:0] chain     = '0;
    logic [3:0] sysdata   = '0;
    logic [3:0] upd_latch = '0;
    assign BSR_TDO = chain[0];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_chain();
        return (mir == OP_EXTEST) || (mir == OP_SAMPLE);
    endfunction

    // Boundary chain environment: strobes snapshotted mid-cycle, applied at rising Clock.
    initial begin
        bit c, s, u, t;
        forever begin
            @(negedge Clock);
            #3;
            c = Clock_DR; s = Shift_or_Load; u = Update_DR; t = TDI;
            @(posedge Clock);
            if (u) upd_latch = chain;
            if (c) chain = s ? {t, chain[3:1]} : sysdata;
        end
    end

    // Monitor: one control record per cycle, one TDO bit whenever the DUT enables TDO.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            #1;
            if (ctrl_q.size() > 0) begin
                e = ctrl_q.pop_front();
                chk("tap_state", int'(Tap_State), e.st);
                chk("chain_strobes", int'({Clock_DR, Shift_or_Load, Update_DR}),
                    int'({e.cdr, e.sol, e.upd}));
                chk("test_or_normal", int'(Test_or_Normal), int'(e.ton));
                chk("tdo_en", int'(TDO_En), int'(e.en));
                if (!e.en) chk("tdo_idle", int'(TDO), 0);
            end
            if (TDO_En) begin
                if (tdo_q.size() == 0) chk("tdo_unexpected", int'(TDO_En), 0);
                else chk("tdo", int'(TDO), int'(tdo_q.pop_front()));
            end
        end
    end

    task automatic step(input bit tms, input bit tdi);
        exp_t e;
        @(negedge Clock);
        #2;
        TMS = tms;
        TDI = tdi;
        case (ms)
            CPI: begin
                irq.delete();
                for (int i = 0; i < IRW; i++) irq.push_back(i == 0);
            end
            SHI: begin
                void'(irq.pop_front());
                irq.push_back(tdi);
            end
            UPI: begin
                for (int i = 0; i < IRW; i++) mir[i] = (i < irq.size()) ? irq[i] : 1'b0;
                mton = (mir == OP_EXTEST);
            end
            CPD: begin
                drq.delete();
                if (m_chain()) for (int i = 0; i < 4; i++) drq.push_back(sysdata[i]);
                else if (mir == OP_IDCODE) for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
                else drq.push_back(1'b0);
            end
            SHD: begin
                void'(drq.pop_front());
                drq.push_back(tdi);
            end
            default: ;
        endcase
        ms = tms ? NXT1[ms] : NXT0[ms];
        if (ms == TLR) begin
            mir  = OP_IDCODE;
            mton = 1'b0;
        end
        e.st  = ms;
        e.en  = (ms == SHI) || (ms == SHD);
        e.cdr = m_chain() && (ms == CPD || ms == SHD);
        e.sol = m_chain() && (ms == SHD);
        e.upd = m_chain() && (ms == UPD);
        e.ton = mton;
        ctrl_q.push_back(e);
        if (ms == SHI) tdo_q.push_back(irq.size() > 0 ? irq[0] : 1'b0);
        if (ms == SHD) tdo_q.push_back(drq.size() > 0 ? drq[0] : 1'b0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_state", int'(Tap_State), TLR);
        chk("rst_strobes", int'({Clock_DR, Shift_or_Load, Update_DR}), 0);
        chk("rst_ton", int'(Test_or_Normal), 0);
        chk("rst_tdo", int'({TDO, TDO_En}), 0);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        #2;
        TMS     = 1'b1;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs();
        ms   = TLR;
        mir  = OP_IDCODE;
        mton = 1'b0;
        irq.delete();
        drq.delete();
        #1;
        Reset_n = 1'b1;
    endtask

    // Run-Test/Idle -> load an opcode -> Run-Test/Idle.
    task automatic load_ir(input logic [3:0] op);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < IRW; i++) step(i == IRW - 1, op[i]);
        step(1, 0); step(0, 0);
    endtask

    // Run-Test/Idle -> shift n bits of pat (LSB first) -> Update-DR -> Run-Test/Idle.
    task automatic shift_dr(input int n, input logic [31:0] pat);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < n; i++) step(i == n - 1, pat[i]);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] p;
        TMS = 1'b1; TDI = 1'b0; Reset_n = 1'b1;
        ms = TLR; mir = OP_IDCODE; mton = 1'b0;
        #2 Reset_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge Clock);
        #4 Reset_n = 1'b1;

        // TLR -> RTI, five ones back to TLR, then RTI again.
        step(0, 0);
        repeat (5) step(1, 0);
        step(0, 0);

        // IDCODE is the post-reset instruction: 32 bits of IDCODE_VAL, LSB first.
        shift_dr(32, $urandom());

        // EXTEST: IR capture reads 1,0,0,0; chain is driven afterwards.
        load_ir(OP_EXTEST);
        @(posedge Clock); #1;
        chk("extest_ton", int'(Test_or_Normal), 1);
        sysdata = 4'($urandom());
        shift_dr(4, 32'($urandom()));

        // BYPASS: TDI 1,0,1,1 appears on TDO as 0,1,0,1; unknown opcode behaves the same.
        load_ir(4'b1111);
        shift_dr(4, 32'b1101);
        load_ir(4'b0110);
        shift_dr(6, 32'($urandom()));

        // SAMPLE with the 4-cell chain; the update latch receives the shifted pattern.
        load_ir(OP_SAMPLE);
        sysdata = 4'($urandom());
        p = 4'($urandom());
        shift_dr(4, 32'(p));
        @(posedge Clock); #1;
        chk("sample_update_latch", int'(upd_latch), int'(p));
        chk("sample_ton", int'(Test_or_Normal), 0);

        // IDCODE with a pause and Exit2 re-entry, then a reset mid Shift-DR.
        do_reset();
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(i == 4, 1'($urandom()));
        step(0, 0); step(0, 0); step(1, 0); step(0, 0);
        for (int i = 0; i < 7; i++) step(i == 6, 1'($urandom()));
        step(1, 0); step(0, 0);
        step(1, 0); step(0, 0); step(0, 0);
        repeat (6) step(0, 1'($urandom()));
        do_reset();

        // Random TMS/TDI walk with occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            if (ms == RTI) sysdata = 4'($urandom());
            if ($urandom_range(0, 399) == 0) do_reset();
            else step($urandom_range(0, 9) < 3, 1'($urandom()));
        end

        repeat (2) @(negedge Clock);
        #2;
        chk("ctrl_queue_drained", ctrl_q.size(), 0);
        chk("tdo_queue_drained", tdo_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
